// File: rtl/alu_pkg.sv
// Shared definitions for the binary ALU front end.
// Holds the op encodings, the legal datapath width and the bundles passed between the two stages.
package alu_pkg;

   localparam int DW_LEGAL = 8;

   localparam logic [2:0] ALU_ADC  = 3'b000;
   localparam logic [2:0] ALU_SBC  = 3'b001;
   localparam logic [2:0] ALU_CMP  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_ORA  = 3'b100;
   localparam logic [2:0] ALU_EOR  = 3'b101;
   localparam logic [2:0] ALU_PASS = 3'b110;

   // Operands registered by stage 1.
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       dec;
      logic [2:0] op;
   } s1_t;

   // Result bundle registered by stage 2.
   typedef struct packed {
      logic [7:0] datai;
      logic       cin4;
      logic       cin8;
      logic       bcd_en;
      logic       sub;
      logic       n;
      logic       z;
      logic       v;
      logic       v_we;
      logic       c_we;
   } res_t;

endpackage

// File: rtl/alu_core.sv
// Combinational add/subtract/logic core: binary result, nibble and byte carries, flags.
// Ports: opnd (a, b, cin, dec, op) in; res (datai, cin4, cin8, bcd_en, sub, n, z, v, v_we, c_we) out.
module alu_core
   import alu_pkg::*;
#(
   parameter bit BCD_ENABLE = 1'b1
) (
   input  s1_t  opnd,
   output res_t res
);

   logic       is_arith;
   logic       is_sub;
   logic       c0;
   logic [7:0] bb;
   logic [4:0] lo;
   logic [8:0] full;

   always_comb begin
      is_arith = (opnd.op == ALU_ADC) | (opnd.op == ALU_SBC) | (opnd.op == ALU_CMP);
      is_sub   = (opnd.op == ALU_SBC) | (opnd.op == ALU_CMP);
      bb       = is_sub ? ~opnd.b : opnd.b;
      // CMP always subtracts without incoming borrow.
      c0       = (opnd.op == ALU_CMP) ? 1'b1 : opnd.cin;
      lo       = {1'b0, opnd.a[3:0]} + {1'b0, bb[3:0]} + {4'd0, c0};
      full     = {1'b0, opnd.a} + {1'b0, bb} + {8'd0, c0};
   end

   always_comb begin
      res = '0;
      unique case (1'b1)
         is_arith: begin
            res.datai  = full[7:0];
            res.cin4   = lo[4];
            res.cin8   = full[8];
            res.v      = (opnd.a[7] == bb[7]) & (full[7] != opnd.a[7]);
            res.sub    = is_sub;
            res.bcd_en = BCD_ENABLE & opnd.dec & (opnd.op != ALU_CMP);
            res.v_we   = (opnd.op != ALU_CMP);
            res.c_we   = 1'b1;
         end
         (opnd.op == ALU_AND): res.datai = opnd.a & opnd.b;
         (opnd.op == ALU_ORA): res.datai = opnd.a | opnd.b;
         (opnd.op == ALU_EOR): res.datai = opnd.a ^ opnd.b;
         default:              res.datai = opnd.a;
      endcase
      // Logic ops route C through cin8 so the downstream carry-out keeps it.
      if (!is_arith) res.cin8 = opnd.cin;
      res.n = res.datai[7];
      res.z = (res.datai == 8'h00);
   end

endmodule

// File: rtl/alu_addsub_pipe.sv
// Two-stage pipelined ALU front end feeding the BCD adjust stage, with valid/ready handshake.
// Ports: clk, reset, flush; in_valid/in_ready, in_a/in_b/in_cin/in_dec/in_op; out_valid/out_ready, datai..c_we.
module alu_addsub_pipe
   import alu_pkg::*;
#(
   parameter bit BCD_ENABLE = 1'b1,
   parameter int DW         = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_a,
   input  logic [DW-1:0] in_b,
   input  logic          in_cin,
   input  logic          in_dec,
   input  logic [2:0]    in_op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] datai,
   output logic          cin4,
   output logic          cin8,
   output logic          bcd_en,
   output logic          sub,
   output logic          flag_n,
   output logic          flag_z,
   output logic          flag_v,
   output logic          v_we,
   output logic          c_we
);

   if (DW != DW_LEGAL) begin : g_dw_chk
      $error("alu_addsub_pipe: DW must be 8");
   end

   logic s1_valid;
   logic adv1;
   logic adv2;
   logic in_fire;
   s1_t  s1_q;
   res_t res_d;
   res_t res_q;

   assign adv2     = ~out_valid | out_ready;
   assign adv1     = s1_valid & adv2;
   assign in_ready = ~s1_valid | adv2;
   assign in_fire  = in_valid & in_ready;

   alu_core #(
      .BCD_ENABLE(BCD_ENABLE)
   ) u_core (
      .opnd(s1_q),
      .res (res_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (flush) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (in_fire)   s1_valid <= 1'b1;
         else if (adv1) s1_valid <= 1'b0;
         if (adv1)           out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
      end
   end

   // Flush blocks captures but leaves the data contents alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q  <= '0;
         res_q <= '0;
      end else if (!flush) begin
         if (in_fire) s1_q <= '{a: in_a, b: in_b, cin: in_cin, dec: in_dec, op: in_op};
         if (adv1)    res_q <= res_d;
      end
   end

   assign datai  = res_q.datai;
   assign cin4   = res_q.cin4;
   assign cin8   = res_q.cin8;
   assign bcd_en = res_q.bcd_en;
   assign sub    = res_q.sub;
   assign flag_n = res_q.n;
   assign flag_z = res_q.z;
   assign flag_v = res_q.v;
   assign v_we   = res_q.v_we;
   assign c_we   = res_q.c_we;

endmodule
